// File: rtl/fp16_pkg.sv
// Shared fp16 field layout, classes and int16 limits for the fp16 <-> int16 converters.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    localparam logic [15:0] INT16_MAX = 16'h7FFF;
    localparam logic [15:0] INT16_MIN = 16'h8000;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    function automatic fp_class_t classify(input fp16_t x);
        if (x.exp == '0)
            return (x.man == '0) ? CLS_ZERO : CLS_SUB;
        else if (x.exp == '1)
            return (x.man == '0) ? CLS_INF : CLS_NAN;
        else
            return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp16_align_shift.sv
// Bidirectional aligner: scales an 11-bit significand by 2^(exp_eff-25+FRAC_BITS).
// Combinational; with FP2FIX_RNE_EN defined it also returns guard and sticky bits.
module fp16_align_shift #(
    parameter int FRAC_BITS = 0
) (
    input  logic [10:0] sig,
    input  logic [4:0]  exp_eff,
    output logic [26:0] mag
`ifdef FP2FIX_RNE_EN
    ,
    output logic        guard,
    output logic        sticky
`endif
);

    logic [6:0] k;
    logic [6:0] nk;

    assign k  = 7'(exp_eff) + 7'(FRAC_BITS) - 7'd25;
    assign nk = 7'd0 - k;

`ifdef FP2FIX_RNE_EN
    logic [21:0] wide;

    always_comb begin
        wide   = {sig, 11'b0} >> nk[3:0];
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        if (!k[6]) begin
            mag = 27'(sig) << k[3:0];
        end else if (nk >= 7'd12) begin
            sticky = |sig;
        end else begin
            mag    = 27'(wide[21:11]);
            guard  = wide[10];
            sticky = |wide[9:0];
        end
    end
`else
    always_comb begin
        mag = '0;
        if (!k[6])
            mag = 27'(sig) << k[3:0];
        else if (nk < 7'd12)
            mag = 27'(sig >> nk[3:0]);
    end
`endif

endmodule

// File: rtl/fp16_to_fixed.sv
// fp16 -> signed Q(15-FRAC_BITS).FRAC_BITS, 3-stage pipeline, global stall on out_valid & ~out_ready.
// FP2FIX_RNE_EN selects round-half-even; otherwise truncates toward zero.
module fp16_to_fixed
    import fp16_pkg::*;
#(
    parameter int FRAC_BITS = 0,
    parameter int FLAG_EN   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_ovf,
    output logic        out_nan
);

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // S1: unpack / classify
    logic      s1_vld;
    fp16_t     s1_x;
    fp_class_t s1_cls;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else if (!stall) begin
            s1_vld <= in_valid;
            s1_x   <= fp16_t'(in_data);
            s1_cls <= classify(fp16_t'(in_data));
        end
    end

    // S2: align
    logic [10:0] sig;
    logic [4:0]  exp_eff;
    logic [26:0] mag_c;
    logic        big_c;

    assign sig     = {s1_cls == CLS_NORM, s1_x.man};
    assign exp_eff = (s1_cls == CLS_SUB) ? 5'd1 : s1_x.exp;
    assign big_c   = (s1_cls == CLS_NORM) &&
                     (({1'b0, s1_x.exp} + 6'(FRAC_BITS)) >= 6'(BIAS + 15));

    logic        s2_vld;
    logic        s2_sign;
    fp_class_t   s2_cls;
    logic [26:0] s2_mag;
    logic        s2_big;

`ifdef FP2FIX_RNE_EN
    logic guard_c, sticky_c;
    logic s2_guard, s2_sticky;

    fp16_align_shift #(.FRAC_BITS(FRAC_BITS)) u_align (
        .sig     (sig),
        .exp_eff (exp_eff),
        .mag     (mag_c),
        .guard   (guard_c),
        .sticky  (sticky_c)
    );

    always_ff @(posedge clk) begin
        if (!stall) begin
            s2_guard  <= guard_c;
            s2_sticky <= sticky_c;
        end
    end
`else
    fp16_align_shift #(.FRAC_BITS(FRAC_BITS)) u_align (
        .sig     (sig),
        .exp_eff (exp_eff),
        .mag     (mag_c)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
        end else if (!stall) begin
            s2_vld  <= s1_vld;
            s2_sign <= s1_x.sign;
            s2_cls  <= s1_cls;
            s2_mag  <= mag_c;
            s2_big  <= big_c;
        end
    end

    // S3: round, saturate, apply sign
    logic [27:0] rmag;
    logic [15:0] data_c;
    logic        ovf_c;
    logic        nan_c;

`ifdef FP2FIX_RNE_EN
    assign rmag = {1'b0, s2_mag} + 28'(s2_guard & (s2_sticky | s2_mag[0]));
`else
    assign rmag = {1'b0, s2_mag};
`endif

    always_comb begin
        data_c = s2_sign ? (16'd0 - rmag[15:0]) : rmag[15:0];
        ovf_c  = 1'b0;
        nan_c  = 1'b0;
        if (s2_cls == CLS_NAN) begin
            data_c = '0;
            nan_c  = 1'b1;
        end else if (!s2_sign && (s2_cls == CLS_INF || s2_big || rmag > 28'd32767)) begin
            data_c = INT16_MAX;
            ovf_c  = 1'b1;
        end else if (s2_sign && (s2_cls == CLS_INF || rmag > 28'd32768)) begin
            data_c = INT16_MIN;
            ovf_c  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_vld;
            out_data  <= data_c;
            out_ovf   <= ovf_c & (FLAG_EN != 0);
            out_nan   <= nan_c & (FLAG_EN != 0);
        end
    end

endmodule

// File: doc/fp16_to_fixed.md
Name: fp16_to_fixed

Overview:
- Pipelined converter from IEEE-754 half precision (fp16) back to signed 16-bit two's-complement fixed point.
- Inverse of the int16-to-fp16 path. Sits on the accelerator output side, where fp16 activations/weights return to the integer datapath.
- Streams one conversion per cycle behind a valid/ready handshake, with saturation and exception flags.

Parameters:
FRAC_BITS, 0, fractional bits of the output (0 = plain int16); legal range 0..8
FLAG_EN, 1, 1 = drive ovf/nan flags; 0 = tie flags to 0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts input this cycle
in_data  in  16  fp16 {sign[15], exp[14:10], man[9:0]}
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  16  signed Q(15-FRAC_BITS).FRAC_BITS result
out_ovf  out  1  result saturated (|x| too large, or ±inf)
out_nan  out  1  input was NaN

Behaviour:
- One clock; reset synchronous, active-high. On rst all stage valids, out_valid, out_data, out_ovf and out_nan clear to 0. Reset mid-stream drops in-flight samples; no output after reset until new input.
- Three-stage pipeline, latency 3 cycles from accepted input to out_valid.
- Global stall: stall = out_valid & ~out_ready.
  - When stalled, all stages hold and in_ready=0.
  - Otherwise all stages advance and in_ready=1.
  - Bubbles are not compressed.
  - out_data and flags stay stable while stalled.
- S1 unpack/classify:
  - Capture sign s, e, m.
  - Class ZERO: e=0, m=0.
  - Class SUB: e=0, m≠0; magnitude m·2^-24.
  - Class NORM: 1≤e≤30; magnitude {1,m}·2^(e-25).
  - Class INF: e=31, m=0.
  - Class NAN: e=31, m≠0.
- S2 align:
  - Significand sig = {1,m} (NORM) or {0,m} (SUB, e treated as 1).
  - Shift k = e_eff - 25 + FRAC_BITS.
  - If k≥0: mag = sig<<k in a 27-bit field.
  - If k<0: mag = sig>>(-k), keeping guard bit (last bit shifted out) and sticky (OR of the rest). Shifts ≥12 give mag=0 with sticky = (sig≠0).
  - Overflow pre-check: big = (NORM and e-15+FRAC_BITS ≥ 15).
- S3 round/sign/saturate:
  - Rounding per Optional Feature; a round-up carry may create overflow and is re-checked.
  - NAN: out_data=0x0000, out_nan=1.
  - INF, or magnitude > 32767 with s=0: out_data=0x7FFF, out_ovf=1.
  - INF, or magnitude > 32768 with s=1: out_data=0x8000, out_ovf=1.
  - Magnitude exactly 32768 with s=1: out_data=0x8000, out_ovf=0.
  - Otherwise out_data = s ? -mag : mag.
  - -0 (0x8000 input) gives 0x0000.
- Flags are 0 when FLAG_EN=0.

Optional Feature:
- Macro FP2FIX_RNE_EN.
- Defined: round half to nearest even using guard/sticky, i.e. increment if guard & (sticky | lsb). Applies to the magnitude before negation, so rounding is symmetric about zero.
- Undefined: truncate toward zero, matching the truncating int-to-fp direction; guard/sticky logic is removed.
- Latency is 3 either way.

Decomposition:
- Shared package fp16_pkg:
  - Field widths: EXP_W=5, MAN_W=10.
  - BIAS=15.
  - Class enum {ZERO, SUB, NORM, INF, NAN}.
  - Constants INT16_MAX=0x7FFF, INT16_MIN=0x8000.
  - fp16 struct typedef.
  - The int-to-fp converter reuses the package.
- One natural sub-module: fp16_align_shift, the bidirectional shifter producing mag, guard and sticky in S2.

Test Plan:
- 0x3C00, 0xC500, 0x0000, 0x8000 back-to-back with out_ready=1 -> 0x0001, 0xFFFB, 0x0000, 0x0000, first output on cycle 3, one per cycle, flags 0.
- 0x3E00 (1.5), 0x4100 (2.5), 0xBE00 (-1.5) -> truncate: 1, 2, -1. RNE: 2, 2, -2.
- 0x7800 (32768), 0xF800 (-32768), 0x7C00 (+inf), 0xFC00 (-inf) -> 0x7FFF ovf=1; 0x8000 ovf=0; 0x7FFF ovf=1; 0x8000 ovf=1.
- 0x7E00 (NaN) and 0x0001 (min subnormal) -> 0x0000 with nan=1; 0x0000 with no flags. Repeat the subnormal with FRAC_BITS=8, input 0x1C00 (2^-8) -> 0x0001.
- Backpressure:
  - Stream 10 random samples and hold out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 during the stall, out_data stable, no loss or duplication, order preserved against a reference model.
  - Assert rst for one cycle mid-stream -> out_valid=0 next cycle, no stale output emerges afterwards.
